mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- iREN  in  1  instruction-fetch read request.
- iaddr  in  32  instruction word address.
- iwait  out  1  instruction request not yet complete.
- iload  out  32  instruction read data.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dwait  out  1  data request not yet complete.
- dload  out  32  data read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ram_ready  in  1  one-cycle pulse: current RAM access complete.

Function
REQ-002 SHALL implement a three-state FSM: IDLE, IGRANT, DGRANT.
REQ-003 SHALL define a data request as dREN|dWEN; when both dREN and dWEN are high, SHALL treat the request as a write.
REQ-004 In IDLE, with one request pending, SHALL move to the matching grant state on the next edge.
REQ-005 In IDLE, with both requests pending, SHALL choose the winner per REQ-016/REQ-017.
REQ-006 In IDLE, SHALL drive ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
REQ-007 In IDLE, SHALL hold iwait=1 while iREN=1 and dwait=1 while a data request is pending; otherwise each wait SHALL be 0.
REQ-008 In IGRANT, SHALL drive ramREN=1, ramWEN=0, ramaddr=iaddr; iwait SHALL equal ~ram_ready.
REQ-009 In DGRANT, SHALL drive ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN; dwait SHALL equal ~ram_ready.
REQ-010 In a grant state, the non-granted port's wait SHALL be 1 if that port is requesting, else 0.
REQ-011 iload and dload SHALL pass ramload combinationally; values are valid only in the cycle their wait is 0 in a grant state.
REQ-012 On ram_ready in a grant state, SHALL return to IDLE on the next edge, giving one bubble cycle before the next grant.
REQ-013 If the granted request drops before ram_ready, SHALL deassert RAM strobes combinationally and return to IDLE on the next edge; no completion is signalled.
REQ-014 SHALL ignore ram_ready in IDLE.
REQ-015 Address and store inputs SHALL be sampled combinationally each cycle; requesters SHALL hold them stable until their wait is 0.

Configuration
REQ-016 With macro MEM_ARBITER_RR_EN defined:
- SHALL keep a 1-bit last-grant register, reset to "instruction".
- On a simultaneous request, SHALL grant the port not granted last.
- SHALL update the register on each grant-state entry.
REQ-017 Without MEM_ARBITER_RR_EN:
- SHALL grant data on a simultaneous request (fixed priority).
- SHALL instantiate no last-grant register.

Reset
REQ-018 While RST=1 at an edge, SHALL enter IDLE and clear the last-grant register (when present), including during an access in progress.
REQ-019 During and immediately after reset, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0; iwait and dwait SHALL follow REQ-007.

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- Lone fetch: iREN=1, iaddr=0x100, ram_ready after 3 cycles, ramload=0x3C010001 -> ramREN=1, ramaddr=0x100 for 3 cycles; iwait=0 and iload=0x3C010001 in the ram_ready cycle; IDLE next.
- Lone store: dWEN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF until ram_ready; dwait low that cycle.
- Collision: iREN and dREN held high together for 4 accesses, ram_ready 1 cycle after each grant.
  - Round-robin build: grant order D,I,D,I.
  - Fixed-priority build: D,D,D,D, with iwait=1 throughout.
- Reset mid-access: RST=1 two cycles into DGRANT -> next cycle IDLE, strobes 0; a later ram_ready is ignored.
- Request drop: iREN falls during IGRANT before ram_ready -> ramREN=0 that cycle; IDLE next; iwait never pulses low.
- dREN=dWEN=1 -> write performed (ramWEN=1, ramREN=0).

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single-ported RAM.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; default is fixed data priority.
module mem_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready
);

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  state_t state;
  state_t cur;
  logic   dreq;
  logic   pick_data;
  logic   grant_data;

  assign dreq = dREN | dWEN;

`ifdef MEM_ARBITER_RR_EN
  // Set when the most recent grant went to the data port.
  logic last_data;
  assign pick_data = ~last_data;
`else
  assign pick_data = 1'b1;
`endif

  // Data wins when it is the only requester or when the tie-break favours it.
  assign grant_data = dreq & (~iREN | pick_data);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
`ifdef MEM_ARBITER_RR_EN
      last_data <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (iREN | dreq) begin
            state <= grant_data ? DGRANT : IGRANT;
`ifdef MEM_ARBITER_RR_EN
            last_data <= grant_data;
`endif
          end
        end
        IGRANT:  if (ram_ready | ~iREN) state <= IDLE;
        DGRANT:  if (ram_ready | ~dreq) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reset forces idle outputs in the same cycle, even mid-access.
  assign cur = RST ? IDLE : state;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = dreq;
    case (cur)
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = ~(ram_ready & iREN);
      end
      DGRANT: begin
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~(ram_ready & dreq);
      end
      default: ;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam int NONE  = 0;
  localparam int INSTR = 1;
  localparam int DATA  = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, ram_ready = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  mem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who currently owns the RAM, and who was served last.
  int owner     = NONE;
  bit last_data = 1'b0;
  bit m_dreq;

  always @(posedge CLK) begin
    m_dreq = dREN | dWEN;
    if (RST) begin
      owner     = NONE;
      last_data = 1'b0;
    end else if (owner == NONE) begin
      if (iREN && m_dreq)  owner = (RR && last_data) ? INSTR : DATA;
      else if (m_dreq)     owner = DATA;
      else if (iREN)       owner = INSTR;
      if (owner != NONE) last_data = (owner == DATA);
    end else if (owner == INSTR) begin
      if (ram_ready || !iREN) owner = NONE;
    end else begin
      if (ram_ready || !m_dreq) owner = NONE;
    end
  end

  // Expected outputs for the current cycle, shared with the stimulus loop.
  logic        e_iwait, e_dwait, e_ren, e_wen, c_dreq;
  logic [31:0] e_addr, e_store;
  int          eff;

  always @(negedge CLK) begin
    #2;
    c_dreq  = dREN | dWEN;
    eff     = RST ? NONE : owner;
    e_ren   = 1'b0;
    e_wen   = 1'b0;
    e_addr  = '0;
    e_store = '0;
    e_iwait = iREN;
    e_dwait = c_dreq;
    if (eff == INSTR) begin
      e_ren   = iREN;
      e_addr  = iaddr;
      e_iwait = !(ram_ready && iREN);
    end else if (eff == DATA) begin
      e_ren   = dREN && !dWEN;
      e_wen   = dWEN;
      e_addr  = daddr;
      e_store = dstore;
      e_dwait = !(ram_ready && c_dreq);
    end
    check("iwait",    {31'b0, iwait},  {31'b0, e_iwait});
    check("dwait",    {31'b0, dwait},  {31'b0, e_dwait});
    check("ramREN",   {31'b0, ramREN}, {31'b0, e_ren});
    check("ramWEN",   {31'b0, ramWEN}, {31'b0, e_wen});
    check("ramaddr",  ramaddr,  e_addr);
    check("ramstore", ramstore, e_store);
    check("iload",    iload,    ramload);
    check("dload",    dload,    ramload);
  end

  // Apply one cycle of inputs at the falling edge; returns after the model compare.
  task automatic drive(input bit rst, input bit ir, input logic [31:0] ia,
                       input bit dr, input bit dw, input logic [31:0] da,
                       input logic [31:0] ds, input bit rdy, input logic [31:0] rl);
    @(negedge CLK);
    RST = rst; iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
    daddr = da; dstore = ds; ram_ready = rdy; ramload = rl;
    #3;
  endtask

  task automatic reset_dut();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  bit          ion, don, r_dr, r_dw, r_rst, i_done, d_done, exp_d;
  int          kind;
  logic [31:0] r_ia, r_da, r_ds;

  initial begin
    // Reset state; ram_ready in idle is ignored.
    reset_dut();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA_5555);
    check("rst_ramREN",   {31'b0, ramREN}, 32'd0);
    check("rst_ramWEN",   {31'b0, ramWEN}, 32'd0);
    check("rst_ramaddr",  ramaddr, 32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    check("rst_iwait",    {31'b0, iwait}, 32'd0);
    check("rst_dwait",    {31'b0, dwait}, 32'd0);

    // Lone fetch, RAM ready on the third strobe cycle.
    drive(0, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    check("fetch_idle_iwait",  {31'b0, iwait},  32'd1);
    check("fetch_idle_ramREN", {31'b0, ramREN}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 32'h100, 0, 0, 0, 0, k == 2, 32'h3C01_0001);
      check("fetch_ramREN",  {31'b0, ramREN}, 32'd1);
      check("fetch_ramaddr", ramaddr, 32'h100);
      check("fetch_iwait",   {31'b0, iwait}, (k == 2) ? 32'd0 : 32'd1);
    end
    check("fetch_iload", iload, 32'h3C01_0001);
    drive(0, 0, 32'h100, 0, 0, 0, 0, 0, 0);
    check("fetch_after_ramaddr", ramaddr, 32'd0);

    // Lone store.
    drive(0, 0, 0, 0, 1, 32'h200, 32'hDEAD_BEEF, 0, 0);
    check("store_idle_dwait", {31'b0, dwait}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 1, 32'h200, 32'hDEAD_BEEF, k == 1, 0);
      check("store_ramWEN",   {31'b0, ramWEN}, 32'd1);
      check("store_ramREN",   {31'b0, ramREN}, 32'd0);
      check("store_ramstore", ramstore, 32'hDEAD_BEEF);
      check("store_ramaddr",  ramaddr, 32'h200);
      check("store_dwait",    {31'b0, dwait}, (k == 1) ? 32'd0 : 32'd1);
    end
    drive(0, 0, 0, 0, 1, 32'h200, 32'hDEAD_BEEF, 0, 0);
    check("store_bubble_ramWEN", {31'b0, ramWEN}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Collision: both held high for four accesses.
    reset_dut();
    for (int a = 0; a < 4; a++) begin
      exp_d = !RR || (a % 2 == 0);
      drive(0, 1, 32'h10, 1, 0, 32'h20, 0, 0, 0);
      check("coll_idle_ramREN", {31'b0, ramREN}, 32'd0);
      check("coll_idle_iwait",  {31'b0, iwait},  32'd1);
      drive(0, 1, 32'h10, 1, 0, 32'h20, 0, 0, 0);
      check("coll_grant_addr",  ramaddr, exp_d ? 32'h20 : 32'h10);
      check("coll_grant_iwait", {31'b0, iwait}, 32'd1);
      drive(0, 1, 32'h10, 1, 0, 32'h20, 0, 1, 0);
      check("coll_done_iwait", {31'b0, iwait}, exp_d ? 32'd1 : 32'd0);
      check("coll_done_dwait", {31'b0, dwait}, exp_d ? 32'd0 : 32'd1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a data access.
    reset_dut();
    drive(0, 0, 0, 1, 0, 32'h300, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 32'h300, 0, 0, 0);
    check("rstmid_grant_ramREN", {31'b0, ramREN}, 32'd1);
    drive(1, 0, 0, 1, 0, 32'h300, 0, 0, 0);
    check("rstmid_during_ramREN", {31'b0, ramREN}, 32'd0);
    drive(0, 0, 0, 1, 0, 32'h300, 0, 1, 0);
    check("rstmid_after_ramREN",  {31'b0, ramREN}, 32'd0);
    check("rstmid_after_ramaddr", ramaddr, 32'd0);
    check("rstmid_ready_ignored", {31'b0, dwait}, 32'd1);
    drive(0, 0, 0, 1, 0, 32'h300, 0, 0, 0);
    check("rstmid_regrant", {31'b0, ramREN}, 32'd1);
    drive(0, 0, 0, 1, 0, 32'h300, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Fetch request withdrawn before the RAM answers.
    reset_dut();
    drive(0, 1, 32'h400, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h400, 0, 0, 0, 0, 0, 0);
    check("drop_grant_ramREN", {31'b0, ramREN}, 32'd1);
    drive(0, 0, 32'h400, 0, 0, 0, 0, 0, 0);
    check("drop_ramREN", {31'b0, ramREN}, 32'd0);
    check("drop_iwait",  {31'b0, iwait},  32'd1);
    drive(0, 0, 32'h400, 0, 0, 0, 0, 0, 0);
    check("drop_idle_ramaddr", ramaddr, 32'd0);

    // Read and write together are treated as a write.
    drive(0, 0, 0, 1, 1, 32'h500, 32'h1234_5678, 0, 0);
    drive(0, 0, 0, 1, 1, 32'h500, 32'h1234_5678, 0, 0);
    check("rw_ramWEN",   {31'b0, ramWEN}, 32'd1);
    check("rw_ramREN",   {31'b0, ramREN}, 32'd0);
    check("rw_ramstore", ramstore, 32'h1234_5678);
    drive(0, 0, 0, 1, 1, 32'h500, 32'h1234_5678, 1, 0);
    check("rw_dwait", {31'b0, dwait}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic; requesters hold until served or occasionally give up.
    reset_dut();
    ion = 0; don = 0; i_done = 0; d_done = 0;
    r_ia = 0; r_da = 0; r_ds = 0; r_dr = 0; r_dw = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!ion || i_done) begin
        ion  = $urandom_range(0, 1) == 1;
        r_ia = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
        ion = 0;
      end
      if (!don || d_done) begin
        don  = $urandom_range(0, 1) == 1;
        kind = $urandom_range(0, 2);
        r_dr = kind != 1;
        r_dw = kind != 0;
        r_da = $urandom;
        r_ds = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
        don = 0;
      end
      r_rst = $urandom_range(0, 99) == 0;
      drive(r_rst, ion, r_ia, don && r_dr, don && r_dw, r_da, r_ds,
            $urandom_range(0, 2) == 0, $urandom);
      i_done = ion && !e_iwait;
      d_done = don && !e_dwait;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
